// File: rtl/uart_icb_stream_bridge.sv
// ---------------------------------------------------------------------------
// uart_icb_stream_bridge
//
// ICB master placed directly in front of sirv_uart_top. After reset it
// programs the baud divider and enables TX and RX. It then moves bytes
// between two valid/ready streams and the UART data registers:
//   - An upstream byte is latched into a one-entry TX holding register. It is
//     written to txdata once a txdata read reports the FIFO as not full.
//   - rxdata is polled while the one-entry RX holding register is empty. A
//     non-empty read is presented on the downstream stream.
// When both directions want the bus, they take turns.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   o_icb_cmd_*         ICB command channel (valid/ready, addr, read, wdata)
//   o_icb_rsp_*         ICB response channel (valid/ready, rdata)
//   tx_valid/ready/data upstream byte stream into the bridge
//   rx_valid/ready/data downstream byte stream out of the bridge
//   init_done           high once the init register writes have completed
// ---------------------------------------------------------------------------
module uart_icb_stream_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] DIV_VAL   = 32'd138
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_icb_cmd_valid,
  input  logic        o_icb_cmd_ready,
  output logic [31:0] o_icb_cmd_addr,
  output logic        o_icb_cmd_read,
  output logic [31:0] o_icb_cmd_wdata,
  input  logic        o_icb_rsp_valid,
  output logic        o_icb_rsp_ready,
  input  logic [31:0] o_icb_rsp_rdata,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        init_done
);

  localparam logic [31:0] OFS_TXDATA = 32'h00;
  localparam logic [31:0] OFS_RXDATA = 32'h04;
  localparam logic [31:0] OFS_TXCTRL = 32'h08;
  localparam logic [31:0] OFS_RXCTRL = 32'h0C;
  localparam logic [31:0] OFS_DIV    = 32'h18;

  typedef enum logic [2:0] {
    S_INIT_DIV, S_INIT_TXC, S_INIT_RXC, S_IDLE, S_TXCHK, S_TXWR, S_RXRD
  } state_t;

  typedef enum logic {PH_CMD, PH_RSP} phase_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
  } cmd_t;

  // Bus command issued on entry to each non-IDLE state.
  function automatic cmd_t cmd_for(state_t s, logic [7:0] tx_byte);
    cmd_t c;
    c.addr  = BASE_ADDR;
    c.read  = 1'b0;
    c.wdata = '0;
    case (s)
      S_INIT_DIV: begin c.addr = BASE_ADDR + OFS_DIV;    c.wdata = DIV_VAL; end
      S_INIT_TXC: begin c.addr = BASE_ADDR + OFS_TXCTRL; c.wdata = 32'h1;   end
      S_INIT_RXC: begin c.addr = BASE_ADDR + OFS_RXCTRL; c.wdata = 32'h1;   end
      S_TXCHK:    begin c.addr = BASE_ADDR + OFS_TXDATA; c.read  = 1'b1;    end
      S_TXWR:     begin c.addr = BASE_ADDR + OFS_TXDATA; c.wdata = {24'h0, tx_byte}; end
      S_RXRD:     begin c.addr = BASE_ADDR + OFS_RXDATA; c.read  = 1'b1;    end
      default:    ;
    endcase
    return c;
  endfunction

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic        cmd_valid_q, cmd_valid_d;
  cmd_t        cmd_q, cmd_d;
  logic        rsp_ready_q, rsp_ready_d;
  logic        init_done_q, init_done_d;
  logic        last_was_tx_q, last_was_tx_d;
  logic        tx_full_q;
  logic [7:0]  tx_byte_q;
  logic        rx_full_q;
  logic [7:0]  rx_byte_q;

  logic        launch;
  state_t      launch_state;
  logic        tx_clear;
  logic        rx_load;
  logic        rdata_unused;

  // Only the full/empty flag and the data byte of a read are meaningful.
  assign rdata_unused = ^o_icb_rsp_rdata[30:8];

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    phase_d       = phase_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_d         = cmd_q;
    rsp_ready_d   = rsp_ready_q;
    init_done_d   = init_done_q;
    last_was_tx_d = last_was_tx_q;
    launch        = 1'b0;
    launch_state  = state_q;
    tx_clear      = 1'b0;
    rx_load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // With both sides wanting the bus, last_was_tx hands it to the other.
        if (tx_full_q && (rx_full_q || !last_was_tx_q)) begin
          launch        = 1'b1;
          launch_state  = S_TXCHK;
          last_was_tx_d = 1'b1;
        end else if (!rx_full_q) begin
          launch        = 1'b1;
          launch_state  = S_RXRD;
          last_was_tx_d = 1'b0;
        end
      end

      default: begin
        if (phase_q == PH_CMD) begin
          if (!cmd_valid_q) begin
            // Only reachable straight out of reset: the first command goes
            // out on the first clock edge after release.
            launch       = 1'b1;
            launch_state = state_q;
          end else if (o_icb_cmd_ready) begin
            cmd_valid_d = 1'b0;
            rsp_ready_d = 1'b1;
            phase_d     = PH_RSP;
          end
        end else if (o_icb_rsp_valid) begin
          rsp_ready_d = 1'b0;
          state_d     = S_IDLE;
          case (state_q)
            S_INIT_DIV: begin launch = 1'b1; launch_state = S_INIT_TXC; end
            S_INIT_TXC: begin launch = 1'b1; launch_state = S_INIT_RXC; end
            S_INIT_RXC: init_done_d = 1'b1;
            S_TXCHK: begin
              // FIFO full: keep the byte and retry from IDLE.
              if (!o_icb_rsp_rdata[31]) begin
                launch       = 1'b1;
                launch_state = S_TXWR;
              end
            end
            S_TXWR:  tx_clear = 1'b1;
            S_RXRD:  rx_load  = !o_icb_rsp_rdata[31];
            default: ;
          endcase
        end
      end
    endcase

    if (launch) begin
      state_d     = launch_state;
      phase_d     = PH_CMD;
      cmd_valid_d = 1'b1;
      cmd_d       = cmd_for(launch_state, tx_byte_q);
    end
  end

  // -------------------------------------------------------------------------
  // State, bus outputs and holding registers
  // -------------------------------------------------------------------------
  // NOTE: the holding registers are reset along with the FSM; a reset must
  // discard any pending byte rather than replay it after init.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT_DIV;
      phase_q       <= PH_CMD;
      cmd_valid_q   <= 1'b0;
      cmd_q         <= '0;
      rsp_ready_q   <= 1'b0;
      init_done_q   <= 1'b0;
      last_was_tx_q <= 1'b0;
      tx_full_q     <= 1'b0;
      tx_byte_q     <= '0;
      rx_full_q     <= 1'b0;
      rx_byte_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      state_q       <= state_d;
      phase_q       <= phase_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_q         <= cmd_d;
      rsp_ready_q   <= rsp_ready_d;
      init_done_q   <= init_done_d;
      last_was_tx_q <= last_was_tx_d;

      // Capture and clear cannot coincide: tx_ready is low while full.
      if (tx_valid && tx_ready) begin
        tx_full_q <= 1'b1;
        tx_byte_q <= tx_data;
      end else if (tx_clear) begin
        tx_full_q <= 1'b0;
      end

      // Load and drain cannot coincide: RXRD is only issued while empty.
      if (rx_load) begin
        rx_full_q <= 1'b1;
        rx_byte_q <= o_icb_rsp_rdata[7:0];
      end else if (rx_full_q && rx_ready) begin
        rx_full_q <= 1'b0;
      end
    end
  end

  assign o_icb_cmd_valid = cmd_valid_q;
  assign o_icb_cmd_addr  = cmd_q.addr;
  assign o_icb_cmd_read  = cmd_q.read;
  assign o_icb_cmd_wdata = cmd_q.wdata;
  assign o_icb_rsp_ready = rsp_ready_q;
  assign tx_ready        = init_done_q & ~tx_full_q;
  assign rx_valid        = rx_full_q;
  assign rx_data         = rx_byte_q;
  assign init_done       = init_done_q;

endmodule

// File: tb/tb_uart_icb_stream_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for uart_icb_stream_bridge.
// A bench-side UART register slave answers every command one cycle later,
// taking read data from per-register queues. A transaction-level model
// predicts the bridge outputs every cycle. Directed scenarios then pin the
// command log against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_icb_stream_bridge;

  localparam logic [31:0] DIV = 32'd138;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_icb_cmd_valid;
  logic        o_icb_cmd_ready;
  logic [31:0] o_icb_cmd_addr;
  logic        o_icb_cmd_read;
  logic [31:0] o_icb_cmd_wdata;
  logic        o_icb_rsp_valid;
  logic        o_icb_rsp_ready;
  logic [31:0] o_icb_rsp_rdata;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        init_done;

  always #5 clk = ~clk;

  uart_icb_stream_bridge #(.BASE_ADDR(32'h0), .DIV_VAL(DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .o_icb_cmd_valid (o_icb_cmd_valid),
    .o_icb_cmd_ready (o_icb_cmd_ready),
    .o_icb_cmd_addr  (o_icb_cmd_addr),
    .o_icb_cmd_read  (o_icb_cmd_read),
    .o_icb_cmd_wdata (o_icb_cmd_wdata),
    .o_icb_rsp_valid (o_icb_rsp_valid),
    .o_icb_rsp_ready (o_icb_rsp_ready),
    .o_icb_rsp_rdata (o_icb_rsp_rdata),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_data         (rx_data),
    .init_done       (init_done)
  );

  typedef enum int {K_DIV, K_TXC, K_RXC, K_TXCHK, K_TXWR, K_RXRD} kind_t;
  typedef enum int {MP_LAUNCH, MP_IDLE, MP_CMD, MP_RSP} mphase_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
  } bus_cmd_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus controls, written by the main sequence just after a rising edge.
  bit          cmd_ready_ctl = 1'b1;
  bit          rx_ready_ctl  = 1'b1;
  logic [7:0]  txq[$];
  logic [31:0] tx_stat_q[$];
  logic [31:0] rx_q[$];
  bus_cmd_t    log_q[$];

  // Slave state.
  bit          s_pending;
  logic [31:0] s_rdata;

  // Behavioural model.
  mphase_t     m_phase;
  kind_t       m_kind;
  bit          m_init, m_tx_full, m_rx_full, m_last_tx;
  logic [7:0]  m_tx_byte, m_rx_byte;

  function automatic bus_cmd_t exp_cmd(kind_t k, logic [7:0] b);
    bus_cmd_t c;
    c.addr = 32'h0; c.read = 1'b0; c.wdata = 32'h0;
    case (k)
      K_DIV:   begin c.addr = 32'h18; c.wdata = DIV;   end
      K_TXC:   begin c.addr = 32'h08; c.wdata = 32'h1; end
      K_RXC:   begin c.addr = 32'h0C; c.wdata = 32'h1; end
      K_TXCHK: begin c.addr = 32'h00; c.read = 1'b1;   end
      K_TXWR:  begin c.addr = 32'h00; c.wdata = {24'h0, b}; end
      K_RXRD:  begin c.addr = 32'h04; c.read = 1'b1;   end
      default: ;
    endcase
    return c;
  endfunction

  task automatic model_reset();
    m_phase   = MP_LAUNCH;
    m_kind    = K_DIV;
    m_init    = 1'b0;
    m_tx_full = 1'b0;
    m_rx_full = 1'b0;
    m_last_tx = 1'b0;
    m_tx_byte = 8'h0;
    m_rx_byte = 8'h0;
  endtask

  // Compare, drive and model process: everything happens on the falling edge,
  // where DUT outputs are stable and the coming rising edge is fully known.
  initial begin : compare_proc
    bus_cmd_t e;
    bit cmd_fire, rsp_fire, tx_fire, rx_fire;
    o_icb_cmd_ready = 1'b0;
    o_icb_rsp_valid = 1'b0;
    o_icb_rsp_rdata = 32'h0;
    tx_valid = 1'b0;
    tx_data  = 8'h0;
    rx_ready = 1'b0;
    s_pending = 1'b0;
    s_rdata   = 32'h0;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_flags", {27'h0, o_icb_cmd_valid, o_icb_rsp_ready, tx_ready, rx_valid, init_done}, 32'h0);
        check("reset_addr", o_icb_cmd_addr, 32'h0);
        check("reset_wdata", o_icb_cmd_wdata, 32'h0);
        check("reset_read_rxdata", {23'h0, o_icb_cmd_read, rx_data}, 32'h0);
        model_reset();
        s_pending = 1'b0;
        o_icb_cmd_ready = cmd_ready_ctl;
        o_icb_rsp_valid = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        continue;
      end

      // Outputs against the model.
      check("cmd_valid", o_icb_cmd_valid, (m_phase == MP_CMD));
      check("rsp_ready", o_icb_rsp_ready, (m_phase == MP_RSP));
      if (m_phase == MP_CMD) begin
        e = exp_cmd(m_kind, m_tx_byte);
        check("cmd_addr", o_icb_cmd_addr, e.addr);
        check("cmd_read", o_icb_cmd_read, e.read);
        check("cmd_wdata", o_icb_cmd_wdata, e.wdata);
      end
      check("tx_ready", tx_ready, m_init && !m_tx_full);
      check("rx_valid", rx_valid, m_rx_full);
      if (m_rx_full) check("rx_data", rx_data, m_rx_byte);
      check("init_done", init_done, m_init);

      // Drive inputs for this cycle.
      o_icb_cmd_ready = cmd_ready_ctl;
      o_icb_rsp_valid = s_pending;
      o_icb_rsp_rdata = s_rdata;
      tx_valid = (txq.size() != 0);
      tx_data  = (txq.size() != 0) ? txq[0] : 8'h0;
      rx_ready = rx_ready_ctl;

      // Slave: reacts to the handshakes that the coming edge will complete.
      if (o_icb_rsp_valid && o_icb_rsp_ready) s_pending = 1'b0;
      if (o_icb_cmd_valid && o_icb_cmd_ready) begin
        log_q.push_back('{o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata});
        s_pending = 1'b1;
        s_rdata = 32'h0;
        if (o_icb_cmd_read && o_icb_cmd_addr == 32'h0) begin
          if (tx_stat_q.size() != 0) s_rdata = tx_stat_q.pop_front();
        end else if (o_icb_cmd_read && o_icb_cmd_addr == 32'h4) begin
          s_rdata = 32'h8000_0000;
          if (rx_q.size() != 0) s_rdata = rx_q.pop_front();
        end
      end

      // Model: outcome of the coming edge.
      cmd_fire = (m_phase == MP_CMD) && o_icb_cmd_ready;
      rsp_fire = (m_phase == MP_RSP) && o_icb_rsp_valid;
      tx_fire  = tx_valid && m_init && !m_tx_full;
      rx_fire  = m_rx_full && rx_ready;

      case (m_phase)
        MP_LAUNCH: m_phase = MP_CMD;
        MP_IDLE: begin
          if (m_tx_full && (m_rx_full || !m_last_tx)) begin
            m_kind = K_TXCHK; m_last_tx = 1'b1; m_phase = MP_CMD;
          end else if (!m_rx_full) begin
            m_kind = K_RXRD; m_last_tx = 1'b0; m_phase = MP_CMD;
          end
        end
        MP_CMD: if (cmd_fire) m_phase = MP_RSP;
        MP_RSP: if (rsp_fire) begin
          m_phase = MP_IDLE;
          case (m_kind)
            K_DIV: begin m_kind = K_TXC; m_phase = MP_CMD; end
            K_TXC: begin m_kind = K_RXC; m_phase = MP_CMD; end
            K_RXC: m_init = 1'b1;
            K_TXCHK: if (!o_icb_rsp_rdata[31]) begin m_kind = K_TXWR; m_phase = MP_CMD; end
            K_TXWR: m_tx_full = 1'b0;
            K_RXRD: if (!o_icb_rsp_rdata[31]) begin
              m_rx_full = 1'b1; m_rx_byte = o_icb_rsp_rdata[7:0];
            end
            default: ;
          endcase
        end
        default: ;
      endcase

      if (tx_fire) begin
        m_tx_full = 1'b1;
        m_tx_byte = txq.pop_front();
      end
      if (rx_fire) m_rx_full = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int count_cmds(int from, logic [31:0] addr, logic rd);
    int n = 0;
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i].addr == addr && log_q[i].read == rd) n++;
    return n;
  endfunction

  logic [31:0] bp_addr [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h0};
  logic        bp_read [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin : main_proc
    int mark;
    int first;
    int n;
    int hits;

    // Init sequence.
    step(3);
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 100) begin step(1); n++; end
    check("init_done_within_budget", init_done, 1'b1);
    check("init_tx_ready", tx_ready, 1'b1);
    check("init_log_size", (log_q.size() >= 3), 1'b1);
    if (log_q.size() >= 3) begin
      check("init0_addr",  log_q[0].addr,  32'h18);
      check("init0_wdata", log_q[0].wdata, 32'd138);
      check("init0_read",  log_q[0].read,  1'b0);
      check("init1_addr",  log_q[1].addr,  32'h08);
      check("init1_wdata", log_q[1].wdata, 32'h1);
      check("init2_addr",  log_q[2].addr,  32'h0C);
      check("init2_wdata", log_q[2].wdata, 32'h1);
    end

    // TX basic.
    step(5);
    mark = log_q.size();
    txq.push_back(8'hA5);
    n = 0;
    while (count_cmds(mark, 32'h0, 1'b0) == 0 && n < 100) begin step(1); n++; end
    check("txa5_write_seen", count_cmds(mark, 32'h0, 1'b0), 1);
    check("txa5_reads", count_cmds(mark, 32'h0, 1'b1), 1);
    for (int i = mark; i < log_q.size(); i++)
      if (log_q[i].addr == 32'h0 && !log_q[i].read)
        check("txa5_wdata", log_q[i].wdata, 32'h0000_00A5);
    step(3);
    check("txa5_ready_again", tx_ready, 1'b1);

    // TX backpressure and round-robin order.
    step(4);
    tx_stat_q.push_back(32'h8000_0000);
    tx_stat_q.push_back(32'h8000_0000);
    mark = log_q.size();
    txq.push_back(8'h3C);
    n = 0;
    while (txq.size() != 0 && n < 50) begin step(1); n++; end
    hits = 0;
    n = 0;
    while (count_cmds(mark, 32'h0, 1'b0) == 0 && n < 200) begin
      if (tx_ready) hits++;
      step(1);
      n++;
    end
    check("bp_tx_ready_low_cycles", hits, 0);
    check("bp_txdata_reads", count_cmds(mark, 32'h0, 1'b1), 3);
    first = -1;
    for (int i = mark; i < log_q.size(); i++)
      if (first < 0 && log_q[i].addr == 32'h0) first = i;
    check("bp_seq_len", (first >= 0 && first + 6 <= log_q.size()), 1'b1);
    if (first >= 0 && first + 6 <= log_q.size()) begin
      for (int j = 0; j < 6; j++) begin
        check($sformatf("bp_seq%0d_addr", j), log_q[first + j].addr, bp_addr[j]);
        check($sformatf("bp_seq%0d_read", j), log_q[first + j].read, bp_read[j]);
      end
      check("bp_wdata", log_q[first + 5].wdata, 32'h0000_003C);
    end

    // RX path with downstream stall.
    step(4);
    rx_ready_ctl = 1'b0;
    rx_q.push_back(32'h0000_005A);
    n = 0;
    while (!rx_valid && n < 100) begin step(1); n++; end
    check("rx_valid_set", rx_valid, 1'b1);
    check("rx_data_5a", rx_data, 8'h5A);
    mark = log_q.size();
    step(20);
    check("rx_no_poll_while_full", count_cmds(mark, 32'h4, 1'b1), 0);
    check("rx_valid_held", rx_valid, 1'b1);
    rx_ready_ctl = 1'b1;
    step(1);
    check("rx_drained", rx_valid, 1'b0);
    mark = log_q.size();
    n = 0;
    while (count_cmds(mark, 32'h4, 1'b1) < 2 && n < 100) begin step(1); n++; end
    step(3);
    check("rx_polls_resumed", (count_cmds(mark, 32'h4, 1'b1) >= 2), 1'b1);
    check("rx_empty_read_no_valid", rx_valid, 1'b0);

    // Reset during a stalled TXWR command.
    txq.push_back(8'hC3);
    n = 0;
    while (!(o_icb_cmd_valid && o_icb_cmd_addr == 32'h0 && !o_icb_cmd_read) && n < 100) begin
      step(1); n++;
    end
    cmd_ready_ctl = 1'b0;
    step(3);
    check("txwr_stalled_valid", o_icb_cmd_valid, 1'b1);
    check("txwr_stalled_wdata", o_icb_cmd_wdata, 32'h0000_00C3);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_cmd_valid", o_icb_cmd_valid, 1'b0);
    check("rst_async_init_done", init_done, 1'b0);
    step(2);
    cmd_ready_ctl = 1'b1;
    mark = log_q.size();
    rst_n = 1'b1;
    n = 0;
    while (log_q.size() == mark && n < 20) begin step(1); n++; end
    check("rst_first_cmd_seen", (log_q.size() > mark), 1'b1);
    if (log_q.size() > mark) begin
      check("rst_first_cmd_addr",  log_q[mark].addr,  32'h18);
      check("rst_first_cmd_wdata", log_q[mark].wdata, 32'd138);
    end
    step(30);
    check("rst_reinit_done", init_done, 1'b1);
    check("rst_byte_discarded", count_cmds(mark, 32'h0, 1'b0), 0);
    check("rst_tx_ready", tx_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
